// File: rtl/xbar_pkg.sv
// xbar_pkg: shared definitions for the 4x4 router crossbar scheduler.
//   N_PORTS            number of input and output FIFOs
//   DEST_MSB/DEST_LSB  destination field position in a default-width word
//   sched_state_t      scheduler FSM encoding
//   DEF_AE_THR         almost-empty threshold applied at reset
//   def_af_thr()       almost-full threshold applied at reset (depth - 1)
package xbar_pkg;

  localparam int unsigned N_PORTS  = 4;
  localparam int unsigned DEST_MSB = 9;
  localparam int unsigned DEST_LSB = 8;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_AE_THR = 1;

  function automatic int unsigned def_af_thr(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-request round-robin arbiter with a registered priority pointer.
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset (pointer -> 0)
//   req_i    request vector, bit i = requester i
//   gnt_o    one-hot grant (all zero when nothing requests)
// Search starts at the pointer and moves upward mod 4; after a grant to i the
// pointer moves to i+1, otherwise it holds.
module rr_arb4 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (gnt_o == '0 && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xbar_sched.sv
// xbar_sched: scheduler and datapath mux for the 4x4 packet router.
// Pops input-FIFO heads (inputs 0-3) and pushes each word to the output FIFO
// named by its destination field (outputs 4-7 as indices 0-3), one grant per
// output per cycle, round-robin among contending inputs, with almost-full
// backpressure from output occupancy.
//   clk, reset         clock, synchronous active-high reset
//   init               hold in INIT and latch thresholds
//   cfg_af_thr         almost-full threshold
//   cfg_ae_thr         almost-empty threshold (hysteresis build only)
//   in_empty, in_head  input FIFO empty flags and show-ahead heads
//   in_pop             combinational pops, one per input
//   out_count          output FIFO occupancies
//   out_push, out_data registered pushes and words per output
//   state, idle        FSM state and IDLE indicator
// Build option: define SCHED_HYST_EN for per-output blocked flags that set at
// the almost-full threshold and clear only at/below the almost-empty one.
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned CW        = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [CW-1:0]         cfg_af_thr,
  input  logic [CW-1:0]         cfg_ae_thr,
  input  logic [3:0]            in_empty,
  input  logic [4*DATA_W-1:0]   in_head,
  output logic [3:0]            in_pop,
  input  logic [4*CW-1:0]       out_count,
  output logic [3:0]            out_push,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [1:0]            state,
  output logic                  idle
);

  sched_state_t        state_q;
  logic                idle_q;
  logic [CW-1:0]       af_q;
  logic [3:0]          push_q;
  logic [4*DATA_W-1:0] data_q;

  logic [3:0]          at_af;
  logic [3:0]          blocked;
  logic                grant_ok;
  logic [3:0]          req      [N_PORTS];
  logic [3:0]          gnt      [N_PORTS];
  logic [DATA_W-1:0]   sel_word [N_PORTS];

  // push_q covers the word already in flight that out_count does not show yet
  always_comb begin
    at_af = '0;
    for (int unsigned d = 0; d < N_PORTS; d++) begin
      at_af[d] = ({1'b0, out_count[d*CW +: CW]} + {{CW{1'b0}}, push_q[d]})
                 >= {1'b0, af_q};
    end
  end

`ifdef SCHED_HYST_EN
  logic [CW-1:0] ae_q;
  logic [3:0]    blk_q, blk_d;

  always_comb begin
    blk_d = blk_q;
    for (int unsigned d = 0; d < N_PORTS; d++) begin
      if (at_af[d])                          blk_d[d] = 1'b1;
      else if (out_count[d*CW +: CW] <= ae_q) blk_d[d] = 1'b0;
    end
  end

  // at_af is ORed in so the crossing cycle itself is already blocked
  assign blocked = blk_q | at_af;
`else
  logic unused_ae;
  assign unused_ae = ^cfg_ae_thr;
  assign blocked   = at_af;
`endif

  assign grant_ok = (state_q == ACTIVE) && !init;

  always_comb begin
    for (int unsigned d = 0; d < N_PORTS; d++) begin
      req[d] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        req[d][i] = grant_ok && !in_empty[i] && !blocked[d] &&
                    (in_head[i*DATA_W + DATA_W - 2 +: 2] == 2'(d));
      end
    end
  end

  for (genvar d = 0; d < N_PORTS; d++) begin : g_arb
    rr_arb4 u_arb (
      .clk_i   (clk),
      .reset_i (reset),
      .req_i   (req[d]),
      .gnt_o   (gnt[d])
    );
  end

  // Each input requests a single destination, so OR-ing grants never collides
  always_comb begin
    in_pop = '0;
    for (int unsigned d = 0; d < N_PORTS; d++) begin
      sel_word[d] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (gnt[d][i]) sel_word[d] = in_head[i*DATA_W +: DATA_W];
      end
      in_pop = in_pop | gnt[d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q <= '0;
      data_q <= '0;
    end else begin
      for (int unsigned d = 0; d < N_PORTS; d++) begin
        push_q[d] <= |gnt[d];
        if (|gnt[d]) data_q[d*DATA_W +: DATA_W] <= sel_word[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idle_q  <= 1'b0;
      af_q    <= CW'(def_af_thr(OUT_DEPTH));
`ifdef SCHED_HYST_EN
      ae_q    <= CW'(DEF_AE_THR);
      blk_q   <= '0;
`endif
    end else begin
`ifdef SCHED_HYST_EN
      blk_q <= blk_d;
`endif
      case (state_q)
        INIT: begin
          af_q <= cfg_af_thr;
`ifdef SCHED_HYST_EN
          ae_q  <= cfg_ae_thr;
          blk_q <= '0;
`endif
          if (!init) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (init) begin
            state_q <= INIT;
            idle_q  <= 1'b0;
          end else if (in_empty != 4'hF) begin
            state_q <= ACTIVE;
            idle_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (init) begin
            state_q <= INIT;
            idle_q  <= 1'b0;
          end else if (in_empty == 4'hF && push_q == '0) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_push = push_q;
  assign out_data = data_q;
  assign state    = state_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_xbar_sched.sv
// tb_xbar_sched: self-checking bench for xbar_sched. Input FIFOs are modelled
// as queues; every observed pop pushes the popped word onto the scoreboard of
// its destination, and every push is checked against that scoreboard.
// Honours SCHED_HYST_EN for the backpressure scenario.
module tb_xbar_sched;

  localparam int DW = 10;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic            init;
  logic [CW-1:0]   cfg_af_thr;
  logic [CW-1:0]   cfg_ae_thr;
  logic [3:0]      in_empty;
  logic [4*DW-1:0] in_head;
  logic [3:0]      in_pop;
  logic [4*CW-1:0] out_count;
  logic [3:0]      out_push;
  logic [4*DW-1:0] out_data;
  logic [1:0]      state;
  logic            idle;

  xbar_sched #(.DATA_W(10), .OUT_DEPTH(8), .CW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .cfg_af_thr (cfg_af_thr),
    .cfg_ae_thr (cfg_ae_thr),
    .in_empty   (in_empty),
    .in_head    (in_head),
    .in_pop     (in_pop),
    .out_count  (out_count),
    .out_push   (out_push),
    .out_data   (out_data),
    .state      (state),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] sb [4][$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            push_total [4];
  logic [3:0]    pop_seen  = '0;
  logic [3:0]    push_seen = '0;
  logic [3:0]    exp_mask  = '0;
  bit            mon_en    = 1'b0;
  bit            sampled   = 1'b0;
  bit            track0    = 1'b0;

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = (fq[i].size() == 0);
      in_head[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic apply_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_seen[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    if (track0) out_count[CW-1:0] = out_count[CW-1:0] + {3'b000, push_seen[0]};
    pop_seen = '0;
    sampled  = 1'b0;
    refresh();
  endtask

  // Observes one cycle at the falling edge and runs the scoreboard
  task automatic sample();
    logic [DW-1:0] w;
    if (sampled) apply_edge();
    @(negedge clk);
    pop_seen  = in_pop;
    push_seen = out_push;
    sampled   = 1'b1;
    if (mon_en) begin
      n_cmp++;
      if (out_push !== exp_mask) begin
        n_bad++;
        $display("FAIL push_mask: out_push=%b expected=%b", out_push, exp_mask);
      end
      for (int d = 0; d < 4; d++) begin
        if (out_push[d] === 1'b1) begin
          push_total[d]++;
          n_cmp++;
          if (sb[d].size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: out %0d pushed %h, expected no push", d, out_data[d*DW +: DW]);
          end else begin
            w = sb[d].pop_front();
            if (out_data[d*DW +: DW] !== w) begin
              n_bad++;
              $display("FAIL sb_data: out %0d data=%h expected=%h", d, out_data[d*DW +: DW], w);
            end
          end
        end
      end
      exp_mask = '0;
      if (reset !== 1'b1) begin
        for (int i = 0; i < 4; i++) begin
          if (in_pop[i] === 1'b1) begin
            n_cmp++;
            if (fq[i].size() == 0) begin
              n_bad++;
              $display("FAIL pop_empty: input %0d popped=1 expected=0 (empty)", i);
            end else begin
              w = fq[i][0];
              exp_mask[w[9:8]] = 1'b1;
              sb[w[9:8]].push_back(w);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    if (!sampled) sample();
    apply_edge();
  endtask

  task automatic wait_pop(input int lim, output bit got);
    got = 1'b0;
    for (int k = 0; k < lim; k++) begin
      sample();
      if (in_pop != 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      sample();
      if (idle === 1'b1 && fq[0].size() == 0 && fq[1].size() == 0 &&
          fq[2].size() == 0 && fq[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b1; cfg_af_thr = 4'd6; cfg_ae_thr = 4'd2;
    out_count = '0;
    refresh();
    repeat (8) tick();
    sample();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (out_push !== 4'b0000) begin n_bad++; $display("FAIL rst_push: got %b want 0000", out_push); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_cmp++; if (in_pop !== 4'b0000) begin n_bad++; $display("FAIL rst_pop: got %b want 0000", in_pop); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b want 0", idle); end
    reset = 1'b0;
    sample();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL init_hold: got %0d want 0", state); end
    init = 1'b0;
    sample();
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL init_exit: got %0d want 1", state); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL init_idle: got %b want 1", idle); end
    n_cmp++; if (out_push !== 4'b0000) begin n_bad++; $display("FAIL init_push: got %b want 0000", out_push); end
    exp_mask = '0;
    mon_en   = 1'b1;
  endtask

  task automatic test_single();
    bit got, ok;
    tick();
    fq[2].push_back(10'h1A5);
    refresh();
    wait_pop(6, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL single_timeout: pop=0 want 1"); end
    n_cmp++; if (in_pop !== 4'b0100) begin n_bad++; $display("FAIL single_pop: got %b want 0100", in_pop); end
    sample();
    n_cmp++; if (out_push !== 4'b0010) begin n_bad++; $display("FAIL single_push: got %b want 0010", out_push); end
    n_cmp++; if (out_data[19:10] !== 10'h1A5) begin n_bad++; $display("FAIL single_data: got %h want 1a5", out_data[19:10]); end
    settle(ok);
    n_cmp++; if (!ok || state !== 2'd1) begin n_bad++; $display("FAIL single_idle: state=%0d want 1", state); end
  endtask

  task automatic test_rr();
    int exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int n = 0;
    int base;
    bit got, ok;
    tick();
    base = push_total[0];
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) fq[i].push_back({2'b00, 8'(i * 16 + k)});
    refresh();
    for (int c = 0; c < 40 && n < 8; c++) begin
      sample();
      if (in_pop != 4'b0000) begin
        n_cmp++;
        if (in_pop !== 4'(1 << exp_ord[n])) begin
          n_bad++;
          $display("FAIL rr_order: pop #%0d got %b want %b", n, in_pop, 4'(1 << exp_ord[n]));
        end
        n++;
      end
    end
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL rr_count: pops=%0d want 8", n); end
    settle(ok);
    n_cmp++; if (push_total[0] - base != 8) begin n_bad++; $display("FAIL rr_pushes: got %0d want 8", push_total[0] - base); end
    tick();
    fq[3].push_back(10'h033);
    fq[0].push_back(10'h030);
    refresh();
    wait_pop(6, got);
    n_cmp++; if (in_pop !== 4'b0001) begin n_bad++; $display("FAIL rr_ptr_wrap: got %b want 0001", in_pop); end
    sample();
    n_cmp++; if (in_pop !== 4'b1000) begin n_bad++; $display("FAIL rr_ptr_next: got %b want 1000", in_pop); end
    settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_settle: idle=%b want 1", idle); end
  endtask

  task automatic test_cross();
    bit got, ok;
    logic [DW-1:0] w;
    tick();
    for (int i = 0; i < 4; i++) fq[i].push_back({2'(3 - i), 8'(8'hC0 + i)});
    refresh();
    wait_pop(6, got);
    n_cmp++; if (in_pop !== 4'b1111) begin n_bad++; $display("FAIL cross_pop: got %b want 1111", in_pop); end
    sample();
    n_cmp++; if (out_push !== 4'b1111) begin n_bad++; $display("FAIL cross_push: got %b want 1111", out_push); end
    for (int d = 0; d < 4; d++) begin
      w = {2'(d), 8'(8'hC0 + 3 - d)};
      n_cmp++;
      if (out_data[d*DW +: DW] !== w) begin
        n_bad++;
        $display("FAIL cross_data: out %0d got %h want %h", d, out_data[d*DW +: DW], w);
      end
    end
    settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cross_settle: idle=%b want 1", idle); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    bit got, ok;
    tick();
    out_count[CW-1:0] = 4'd5;
    track0 = 1'b1;
    for (int k = 0; k < 6; k++) fq[0].push_back({2'b00, 8'(8'h50 + k)});
    refresh();
    for (int c = 0; c < 10; c++) begin
      sample();
      if (in_pop[0] === 1'b1) pops++;
    end
    n_cmp++; if (pops != 1) begin n_bad++; $display("FAIL bp_stall: pops=%0d want 1", pops); end
    tick();
    out_count[CW-1:0] = 4'd5;
`ifdef SCHED_HYST_EN
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (in_pop[0] === 1'b1) pops++;
    end
    n_cmp++; if (pops != 0) begin n_bad++; $display("FAIL hyst_hold: pops=%0d want 0", pops); end
    tick();
    out_count[CW-1:0] = 4'd2;
    wait_pop(5, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL hyst_resume: pop=0 want 1"); end
`else
    wait_pop(3, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL af_resume: pop=0 want 1"); end
`endif
    tick();
    track0 = 1'b0;
    out_count = '0;
    settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_drain: idle=%b left=%0d want empty", idle, fq[0].size()); end
  endtask

  task automatic test_init_abort();
    bit got, ok;
    tick();
    for (int k = 0; k < 4; k++) fq[1].push_back({2'd2, 8'(8'hA0 + k)});
    refresh();
    wait_pop(6, got);
    n_cmp++; if (in_pop !== 4'b0010) begin n_bad++; $display("FAIL abort_first: got %b want 0010", in_pop); end
    tick();
    init = 1'b1;
    sample();
    n_cmp++; if (in_pop !== 4'b0000) begin n_bad++; $display("FAIL abort_nopop: got %b want 0000", in_pop); end
    n_cmp++; if (out_push !== 4'b0100) begin n_bad++; $display("FAIL abort_push: got %b want 0100", out_push); end
    sample();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", state); end
    tick();
    init = 1'b0;
    settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_drain: idle=%b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    bit got, ok;
    tick();
    for (int k = 0; k < 3; k++) fq[3].push_back({2'd3, 8'(8'hE0 + k)});
    refresh();
    wait_pop(6, got);
    n_cmp++; if (in_pop !== 4'b1000) begin n_bad++; $display("FAIL rmid_pop: got %b want 1000", in_pop); end
    tick();
    reset = 1'b1;
    sample();
    n_cmp++; if (out_push !== 4'b1000) begin n_bad++; $display("FAIL rmid_inflight: got %b want 1000", out_push); end
    sample();
    n_cmp++; if (out_push !== 4'b0000) begin n_bad++; $display("FAIL rmid_drop: got %b want 0000", out_push); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rmid_state: got %0d want 0", state); end
    tick();
    reset = 1'b0;
    settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_drain: idle=%b want 1", idle); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) push_total[d] = 0;
    test_reset();
    test_single();
    test_rr();
    test_cross();
    test_backpressure();
    test_init_abort();
    test_reset_mid();
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (sb[d].size() != 0) begin
        n_bad++;
        $display("FAIL sb_leftover: out %0d pending=%0d want 0", d, sb[d].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xbar_sched.md
Name: xbar_sched

Overview:
- Scheduler and datapath mux for the 4x4 packet router.
- Sits between input FIFOs 0-3 and output FIFOs 4-7.
- Each 10-bit word carries its destination in bits [9:8] (0..3 selects output FIFO 4..7).
- Each cycle it pops input-FIFO heads and pushes them to their destination output FIFOs:
  - round-robin arbitration among inputs that contend for the same output;
  - almost-full backpressure from output-FIFO occupancy.

Parameters:
- DATA_W, 10, word width; destination field is [DATA_W-1:DATA_W-2].
- OUT_DEPTH, 8, output FIFO depth.
- CW, $clog2(OUT_DEPTH)+1, width of occupancy counts and thresholds.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- init  in  1  holds the block in INIT and latches thresholds
- cfg_af_thr  in  CW  almost-full threshold
- cfg_ae_thr  in  CW  almost-empty threshold (used only with SCHED_HYST_EN)
- in_empty  in  4  empty flag per input FIFO
- in_head  in  4*DATA_W  show-ahead head word per input FIFO; input i at [i*DATA_W +: DATA_W]
- in_pop  out  4  pop per input FIFO, combinational from grants
- out_count  in  4*CW  occupancy per output FIFO
- out_push  out  4  push per output FIFO, registered
- out_data  out  4*DATA_W  word per output FIFO, registered
- state  out  2  FSM state
- idle  out  1  high in IDLE

Behaviour:
- Clocking: one clock. Reset is synchronous, active-high; port names are clk and reset.
- Reset values:
  - state=INIT; thresholds af=OUT_DEPTH-1, ae=1.
  - out_push=0, out_data=0, in_pop=0, idle=0.
  - All round-robin pointers=0; blocked flags=0.
- FSM states: INIT=0, IDLE=1, ACTIVE=2.
  - INIT: latch cfg_af_thr/cfg_ae_thr every cycle; no grants; when init=0, go to IDLE.
  - IDLE: if any in_empty bit is 0, go to ACTIVE.
  - ACTIVE: grant per the arbitration rules below.
    - Go to IDLE when all inputs are empty and out_push==0.
  - init=1 in IDLE or ACTIVE: no new grants that cycle; go to INIT. Any already-registered out_push completes normally.
- Request: input i requests dest d when state==ACTIVE, in_empty[i]==0, head[i][9:8]==d, and output d is not blocked.
- Blocking, without hysteresis: output d is blocked when out_count[d] + out_push[d] >= af_thr. The out_push term accounts for the in-flight push not yet reflected in the count.
- Arbitration:
  - One grant per output per cycle; each input requests at most one output, so there are no input conflicts.
  - Up to 4 transfers per cycle.
  - Priority starts at rr_ptr[d] and searches upward mod 4.
  - On a grant to input i, rr_ptr[d] becomes (i+1) mod 4. With no grant, the pointer holds.
- Timing:
  - Grant in cycle N gives in_pop[i]=1 in cycle N.
  - At edge N→N+1: out_push[d]<=1 and out_data[d]<=in_head[i].
  - Latency: head visible to output push is 1 cycle.
  - out_data of a non-pushed output holds its previous value.
- Back-to-back: one input can be popped every cycle. Its new head is re-evaluated the following cycle.
- Reset mid-operation: reset dominates. Any in-flight push is dropped and out_push=0 next cycle.

Optional Feature:
- Macro: SCHED_HYST_EN.
- Defined:
  - Per-output blocked flag: set when out_count+out_push >= af_thr; cleared when out_count <= ae_thr.
  - Grants are suppressed while the flag is set.
  - Flags reset to 0 and clear in INIT.
- Undefined: blocking is purely combinational per the af rule; cfg_ae_thr is ignored.

Decomposition:
- Package xbar_pkg:
  - N_PORTS=4; DEST_MSB=9, DEST_LSB=8.
  - sched_state_t enum {INIT, IDLE, ACTIVE}.
  - Default thresholds.
- Sub-module rr_arb4: 4-request round-robin arbiter with pointer register and one-hot grant; instantiated once per output.

Test Plan:
- Reset 8 cycles, init=1 with af=6/ae=2, then init=0 → state INIT→IDLE; all outputs 0.
- Single word 0x1A5 on input 2 (dest 1), counts 0 → in_pop=0100 in cycle N; out_push=0010 and out_data[1]=0x1A5 in N+1; then IDLE.
- All four inputs head dest 0, each holding 2 words, rr_ptr=0:
  - Pops are single-hot in order 0,1,2,3,0,1,2,3.
  - 8 pushes to output 0.
  - rr_ptr[0] ends at 0.
- Inputs 0..3 with dests 3,2,1,0 simultaneously → in_pop=1111 in the same cycle; out_push=1111 next cycle, data crossed correctly.
- out_count[0] at 5, af=6, continuous dest-0 traffic → one push, then stall.
  - With SCHED_HYST_EN: resumes only when the count drops to 2.
  - Without: resumes once count+push < 6.
- Traffic flowing, then init=1 → no pop in that cycle; the pending push completes; state=INIT. Separately, reset asserted mid-transfer → out_push=0 next cycle.
